// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide dmem.
// Every dmem access is a whole 32-bit word. Byte extraction, sign/zero extension and
// read-modify-write merging are done here. Accesses that straddle a word boundary are
// split into two word accesses.
module lsu_dmem_ctrl #(
  parameter int unsigned DMEM_DEPTH      = 1024,
  parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [31:0]                req_addr,
  input  logic [1:0]                 req_size,
  input  logic                       req_unsigned,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_err,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                mem_din,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [1:0]                 mem_size,
  output logic                       mem_notsigned,
  input  logic [31:0]                mem_dout
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

  localparam logic [DMEM_ADDR_WIDTH-1:0] LAST_W = DMEM_ADDR_WIDTH'(DMEM_DEPTH - 1);

  state_t                     state_q;
  logic                       we_q, uns_q, span_q;
  logic [1:0]                 size_q, off_q;
  logic [DMEM_ADDR_WIDTH-1:0] w_q, w_next;
  logic [31:0]                wdata_q, word0_q, word1_q;

  logic [DMEM_ADDR_WIDTH-1:0] req_w;
  logic [2:0]                 req_nbytes;
  logic                       req_span;
  logic [63:0]                old64, merged;
  logic [31:0]                ld_data;
  logic                       unused_addr_bits;

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_ext(input logic [63:0] d64, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] d;
    d = d64[{off, 3'b000} +: 32];
    case (size)
      2'b00:   load_ext = uns ? {24'b0, d[7:0]}   : {{24{d[7]}}, d[7:0]};
      2'b01:   load_ext = uns ? {16'b0, d[15:0]}  : {{16{d[15]}}, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  // Replace the addressed bytes of an 8-byte window with the right-justified store data.
  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [7:0]  bm;
    logic [31:0] wm;
    logic [63:0] m;
    case (size)
      2'b00:   begin bm = 8'h01; wm = 32'h0000_00FF; end
      2'b01:   begin bm = 8'h03; wm = 32'h0000_FFFF; end
      default: begin bm = 8'h0F; wm = '1;            end
    endcase
    bm = bm << off;
    for (int unsigned i = 0; i < 8; i++) m[i*8 +: 8] = {8{bm[i]}};
    store_merge = (old & ~m) | ({32'b0, wd & wm} << {off, 3'b000});
  endfunction

  assign req_w            = req_addr[DMEM_ADDR_WIDTH+1:2];
  assign req_nbytes       = (req_size == 2'b00) ? 3'd1 : (req_size == 2'b01) ? 3'd2 : 3'd4;
  assign req_span         = ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;
  assign w_next           = (w_q == LAST_W) ? '0 : w_q + 1'b1;
  assign mem_size         = 2'b10;
  assign mem_notsigned    = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:DMEM_ADDR_WIDTH+2]};

  // The 64-bit window being worked on: in RD0/RD1 the word arriving from dmem is folded in
  // before it is registered, so extraction and merge results can be loaded into the
  // registered outputs on the same edge.
  always_comb begin
    old64 = {word1_q, word0_q};
    case (state_q)
      RD0:     old64 = {32'b0, mem_dout};
      RD1:     old64 = {mem_dout, word0_q};
      default: ;
    endcase
    merged  = store_merge(old64, wdata_q, off_q, size_q);
    ld_data = load_ext(old64, off_q, size_q, uns_q);
  end

  // Access sequencer with registered request/response and dmem outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      span_q     <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      w_q        <= '0;
      wdata_q    <= '0;
      word0_q    <= '0;
      word1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            off_q     <= req_addr[1:0];
            w_q       <= req_w;
            wdata_q   <= req_wdata;
            span_q    <= req_span;
            word0_q   <= '0;
            word1_q   <= '0;
            req_ready <= 1'b0;
            if (req_size == 2'b11) begin
              state_q    <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_size == 2'b10 && req_addr[1:0] == 2'b00) begin
              // Aligned full-word store needs no old data: merge of zeros is wdata itself.
              state_q   <= WR0;
              mem_write <= 1'b1;
              mem_addr  <= req_w;
              mem_din   <= req_wdata;
            end else begin
              state_q  <= RD0;
              mem_read <= 1'b1;
              mem_addr <= req_w;
            end
          end
        end
        RD0: begin
          word0_q <= mem_dout;
          if (span_q) begin
            state_q  <= RD1;
            mem_addr <= w_next;
          end else if (!we_q) begin
            state_q    <= DONE;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end else begin
            state_q   <= WR0;
            mem_read  <= 1'b0;
            mem_write <= 1'b1;
            mem_addr  <= w_q;
            mem_din   <= merged[31:0];
          end
        end
        RD1: begin
          word1_q  <= mem_dout;
          mem_read <= 1'b0;
          if (!we_q) begin
            state_q    <= DONE;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end else begin
            state_q   <= WR0;
            mem_write <= 1'b1;
            mem_addr  <= w_q;
            mem_din   <= merged[31:0];
          end
        end
        WR0: begin
          if (span_q) begin
            state_q  <= WR1;
            mem_addr <= w_next;
            mem_din  <= merged[63:32];
          end else begin
            state_q    <= DONE;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
          end
        end
        WR1: begin
          state_q    <= DONE;
          mem_write  <= 1'b0;
          mem_addr   <= '0;
          mem_din    <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        DONE: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a combinational-read / clocked-write dmem model.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_notsigned;
  logic [31:0] mem_dout;

  int checks = 0;
  int failures = 0;
  int both_active = 0;

  logic [31:0] mem [0:1023];
  logic [9:0]  rd_q[$];
  logic [9:0]  wr_q[$];

  lsu_dmem_ctrl #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_notsigned(mem_notsigned), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    if (mem_read) rd_q.push_back(mem_addr);
    if (mem_write) wr_q.push_back(mem_addr);
    if (mem_read && mem_write) both_active++;
  end

  // Issue one request from a post-edge point; lat = index of the edge (after the accept
  // edge) at which resp_valid is presented.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err);
    rd_q.delete();
    wr_q.delete();
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rdata = 'x; err = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid === 1'b1) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL resp_timeout addr=%h got no resp_valid within 20 cycles", addr);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL resp_pulse addr=%h got valid=%b ready=%b expected valid=0 ready=1",
               addr, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    logic [78:0] got, exp;
    repeat (2) @(posedge clk);
    #1;
    got = {req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_din};
    exp = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_state got=%h expected=%h", got, exp);
    end
    checks++;
    if (mem_size !== 2'b10 || mem_notsigned !== 1'b0) begin
      failures++; $display("FAIL mem_consts got size=%b ns=%b expected 10/0", mem_size, mem_notsigned);
    end
    reset_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw_aligned;
    int lat; logic [31:0] rd; logic err;
    mem[4] = 32'hDEADBEEF;
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat != 2) begin
      failures++; $display("FAIL lw_aligned got rdata=%h err=%b lat=%0d expected deadbeef/0/2", rd, err, lat);
    end
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== 10'd4 || wr_q.size() != 0) begin
      failures++; $display("FAIL lw_aligned_mem got reads=%0d writes=%0d expected 1 read at 4, 0 writes",
                           rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_load_ext;
    int lat; logic [31:0] rd; logic err;
    logic [31:0] exp [4];
    logic [31:0] addr [4];
    logic [1:0]  sz [4];
    logic        un [4];
    mem[4] = 32'h80112233;
    addr = '{32'h13, 32'h13, 32'h12, 32'h12};
    sz   = '{2'b00, 2'b00, 2'b01, 2'b01};
    un   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, addr[i], sz[i], un[i], 32'h0, lat, rd, err);
      checks++;
      if (rd !== exp[i] || lat != 2) begin
        failures++; $display("FAIL load_ext[%0d] got rdata=%h lat=%0d expected %h/2", i, rd, lat, exp[i]);
      end
    end
  endtask

  task automatic test_sb;
    int lat; logic [31:0] rd; logic err;
    mem[4] = 32'h11223344;
    do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h000000AA, lat, rd, err);
    checks++;
    if (mem[4] !== 32'h1122AA44 || lat != 3 || rd !== 32'h0) begin
      failures++; $display("FAIL sb got mem4=%h lat=%0d rdata=%h expected 1122aa44/3/0", mem[4], lat, rd);
    end
    checks++;
    if (rd_q.size() != 1 || wr_q.size() != 1 || rd_q[0] !== 10'd4 || wr_q[0] !== 10'd4) begin
      failures++; $display("FAIL sb_mem got reads=%0d writes=%0d expected 1 read and 1 write at 4",
                           rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_lw_split;
    int lat; logic [31:0] rd; logic err;
    mem[3] = 32'hAABBCCDD;
    mem[4] = 32'h11223344;
    do_req(1'b0, 32'h0E, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h3344AABB || lat != 3) begin
      failures++; $display("FAIL lw_split got rdata=%h lat=%0d expected 3344aabb/3", rd, lat);
    end
    checks++;
    if (rd_q.size() != 2 || rd_q[0] !== 10'd3 || rd_q[1] !== 10'd4 || wr_q.size() != 0) begin
      failures++; $display("FAIL lw_split_mem got reads=%0d writes=%0d expected reads 3,4", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_sh_wrap;
    int lat; logic [31:0] rd; logic err;
    mem[1023] = 32'h11223344;
    mem[0]    = 32'h55667788;
    do_req(1'b1, 32'hFFF, 2'b01, 1'b0, 32'h0000BEEF, lat, rd, err);
    checks++;
    if (mem[1023] !== 32'hEF223344 || mem[0] !== 32'h556677BE || lat != 5) begin
      failures++; $display("FAIL sh_wrap got m1023=%h m0=%h lat=%0d expected ef223344/556677be/5",
                           mem[1023], mem[0], lat);
    end
    checks++;
    if (rd_q.size() != 2 || wr_q.size() != 2 || rd_q[0] !== 10'd1023 || rd_q[1] !== 10'd0 ||
        wr_q[0] !== 10'd1023 || wr_q[1] !== 10'd0) begin
      failures++; $display("FAIL sh_wrap_mem got reads=%0d writes=%0d expected 1023,0 for both",
                           rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_sw_aligned;
    int lat; logic [31:0] rd; logic err;
    mem[8] = 32'h12345678;
    do_req(1'b1, 32'hABC00020, 2'b10, 1'b0, 32'hCAFEF00D, lat, rd, err);
    checks++;
    if (mem[8] !== 32'hCAFEF00D || lat != 2) begin
      failures++; $display("FAIL sw_aligned got mem8=%h lat=%0d expected cafef00d/2", mem[8], lat);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 1 || wr_q[0] !== 10'd8) begin
      failures++; $display("FAIL sw_aligned_mem got reads=%0d writes=%0d expected 0 reads, 1 write at 8",
                           rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_illegal;
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 32'h10, 2'b11, 1'b0, 32'h12345678, lat, rd, err);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat != 1) begin
      failures++; $display("FAIL illegal got err=%b rdata=%h lat=%0d expected 1/0/1", err, rd, lat);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++; $display("FAIL illegal_mem got reads=%0d writes=%0d expected none", rd_q.size(), wr_q.size());
    end
  endtask

  // A request presented while busy must not be taken.
  task automatic test_ignore_busy;
    mem[4] = 32'hDEADBEEF;
    rd_q.delete(); wr_q.delete();
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
      failures++; $display("FAIL busy_resp got valid=%b rdata=%h ready=%b expected 1/deadbeef/0",
                           resp_valid, resp_rdata, req_ready);
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem[4] !== 32'hDEADBEEF || wr_q.size() != 0 || rd_q.size() != 1) begin
      failures++; $display("FAIL busy_ignored got mem4=%h writes=%0d reads=%0d expected deadbeef/0/1",
                           mem[4], wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic err;
    mem[5] = 32'h01020304;
    mem[6] = 32'hA0B0C0D0;
    do_req(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, lat, rd, err);
    do_req(1'b0, 32'h19, 2'b00, 1'b1, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h000000C0 || lat != 2) begin
      failures++; $display("FAIL back_to_back got rdata=%h lat=%0d expected 000000c0/2", rd, lat);
    end
  endtask

  task automatic test_reset_mid;
    int  lat; logic [31:0] rd; logic err;
    logic seen;
    logic [78:0] got, exp;
    mem[3] = 32'hAABBCCDD;
    mem[4] = 32'h11223344;
    req_we = 1'b0; req_addr = 32'h0E; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 10'd4) begin
      failures++; $display("FAIL mid_rd1 got read=%b addr=%0d expected 1/4", mem_read, mem_addr);
    end
    reset_b = 1'b0;
    #1;
    got = {req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_din};
    exp = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL mid_reset got=%h expected=%h", got, exp);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    reset_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL mid_no_resp got resp_seen=%b ready=%b expected 0/1", seen, req_ready);
    end
    do_req(1'b0, 32'h0E, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h3344AABB || lat != 3) begin
      failures++; $display("FAIL after_reset got rdata=%h lat=%0d expected 3344aabb/3", rd, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_lw_aligned();
    test_load_ext();
    test_sb();
    test_lw_split();
    test_sh_wrap();
    test_sw_aligned();
    test_illegal();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (both_active != 0) begin
      failures++; $display("FAIL rd_wr_exclusive got %0d cycles with both enables expected 0", both_active);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
